// File: rtl/sensor_rotator_pkg.sv
// sensor_rotator_pkg: Moore state encoding and sensor-count classification for sensor_rotator
package sensor_rotator_pkg;
  typedef enum logic [1:0] {ST_NONE = 2'b00, ST_SOME = 2'b01, ST_ALL = 2'b11} state_t;
  function automatic state_t classify(input int pc, input int n);
    return pc == 0 ? ST_NONE : pc == n ? ST_ALL : ST_SOME;
  endfunction
endpackage

// File: rtl/sensor_rotator_debounce_bit.sv
// sensor_rotator_debounce_bit: one-bit DEB_CYCLES filter, built only with SENSOR_ROTATOR_DEBOUNCE_EN
`ifdef SENSOR_ROTATOR_DEBOUNCE_EN
module sensor_rotator_debounce_bit #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic          last;
  assign last = cnt == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (en) begin
      cnt <= (d == q || last) ? '0 : cnt + 1'b1;
      if (d != q && last) q <= d;
    end
endmodule
`endif

// File: rtl/sensor_rotator.sv
// sensor_rotator: N-sensor NONE/SOME/ALL lamp rotator; SENSOR_ROTATOR_DEBOUNCE_EN adds per-bit debounce
module sensor_rotator
  import sensor_rotator_pkg::*;
#(
  parameter int N        = 2,
  parameter int DWELL    = 1,
  parameter int ROT_MODE = 0
`ifdef SENSOR_ROTATOR_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES = 4
`endif
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N-1:0]         sens,
  output logic [N-1:0]         lamp,
  output logic [1:0]           state,
  output logic [$clog2(N)-1:0] ptr
);
  localparam int PW = $clog2(N);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [N-1:0]  sens_q, eff;
  state_t        st;
  logic [DW-1:0] dwell_cnt;
  logic [PW-1:0] nxt_act, ptr_step;
  logic          step, found;
  int            idx;
`ifdef SENSOR_ROTATOR_DEBOUNCE_EN
  for (genvar i = 0; i < N; i++) begin : g_deb
    sensor_rotator_debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(Clk), .rst(reset), .en(enable), .d(sens_q[i]), .q(eff[i])
    );
  end
`else
  assign eff = sens_q;
`endif
  assign step  = dwell_cnt == DW'(DWELL - 1);
  assign state = st;
  // next active index after ptr, wrapping; holds ptr when no other bit is set
  always_comb begin
    nxt_act = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && eff[PW'(idx)]) begin
        nxt_act = PW'(idx);
        found   = 1'b1;
      end
    end
    ptr_step = ROT_MODE == 1 ? nxt_act : ptr == PW'(N - 1) ? '0 : ptr + 1'b1;
  end
  always_comb
    lamp = !enable ? '0 :
           st == ST_ALL ? '1 :
           (st == ST_SOME && !(ROT_MODE == 1 && !eff[ptr])) ? N'(1) << ptr : '0;
  always_ff @(posedge Clk)
    if (reset) begin
      sens_q    <= '0;
      st        <= ST_NONE;
      ptr       <= '0;
      dwell_cnt <= '0;
    end else if (enable) begin
      sens_q    <= sens;
      st        <= classify($countones(eff), N);
      dwell_cnt <= (st != ST_SOME || step) ? '0 : dwell_cnt + 1'b1;
      if (st == ST_SOME && step) ptr <= ptr_step;
    end
endmodule

// File: tb/tb_sensor_rotator.sv
// tb_sensor_rotator: directed checks of sensor_rotator across three parameter sets
module tb_sensor_rotator;
`ifdef SENSOR_ROTATOR_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, enable;
  logic [1:0] s2, l2, st2;
  logic       p2;
  logic [3:0] s4, l4, s4r, l4r;
  logic [1:0] st4, st4r, p4, p4r;
  int errors = 0, checks = 0;

  sensor_rotator #(.N(2)) d2 (
    .Clk(clk), .reset(reset), .enable(enable), .sens(s2), .lamp(l2), .state(st2), .ptr(p2)
  );
  sensor_rotator #(.N(4), .DWELL(3), .ROT_MODE(0)) d4 (
    .Clk(clk), .reset(reset), .enable(enable), .sens(s4), .lamp(l4), .state(st4), .ptr(p4)
  );
  sensor_rotator #(.N(4), .DWELL(1), .ROT_MODE(1)) d4r (
    .Clk(clk), .reset(reset), .enable(enable), .sens(s4r), .lamp(l4r), .state(st4r), .ptr(p4r)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; s2 = 2'b11; s4 = 4'hf; s4r = 4'hf;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (st2 !== 2'b00) begin errors++; $display("FAIL reset_state cyc%0d: got %b want 00", i, st2); end
      checks++;
      if (p2 !== 1'b0) begin errors++; $display("FAIL reset_ptr cyc%0d: got %b want 0", i, p2); end
      checks++;
      if (l2 !== 2'b00) begin errors++; $display("FAIL reset_lamp cyc%0d: got %b want 00", i, l2); end
    end
    reset = 1'b0;
  endtask

  task automatic test_n2_toggle();
    s2 = 2'b00; s4 = '0; s4r = '0;
    pulse_reset();
    tick(10);
    checks++;
    if (st2 !== 2'b00) begin errors++; $display("FAIL n2_none: got %b want 00", st2); end
    s2 = 2'b01;
    tick(LAT - 1);
    checks++;
    if (st2 !== 2'b00) begin errors++; $display("FAIL n2_some_early: got %b want 00", st2); end
    tick(1);
    checks++;
    if (st2 !== 2'b01) begin errors++; $display("FAIL n2_some: got %b want 01", st2); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (l2 !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL n2_toggle step%0d: got %b want %b", i, l2, (i % 2 == 0 ? 2'b01 : 2'b10));
      end
      tick(1);
    end
    s2 = 2'b11;
    tick(LAT);
    checks++;
    if (st2 !== 2'b11 || l2 !== 2'b11) begin errors++; $display("FAIL n2_all: got st=%b lamp=%b want 11/11", st2, l2); end
    s2 = 2'b00;
    tick(LAT - 1);
    checks++;
    if (st2 !== 2'b11) begin errors++; $display("FAIL n2_all_hold: got %b want 11", st2); end
    tick(1);
    checks++;
    if (st2 !== 2'b00 || l2 !== 2'b00) begin errors++; $display("FAIL n2_back_none: got st=%b lamp=%b want 00/00", st2, l2); end
  endtask

  task automatic wait_some4(input string tag);
    int n = 0;
    while (st4 !== 2'b01 && n < 30) begin tick(1); n++; end
    checks++;
    if (st4 !== 2'b01) begin errors++; $display("FAIL %s_enter_some: got %b want 01 (timeout)", tag, st4); end
  endtask

  task automatic test_dwell();
    logic [3:0] exp;
    s4 = 4'b0101;
    pulse_reset();
    wait_some4("dwell");
    for (int i = 0; i < 15; i++) begin
      exp = 4'(1 << ((i / 3) % 4));
      checks++;
      if (l4 !== exp) begin errors++; $display("FAIL dwell_lamp step%0d: got %b want %b", i, l4, exp); end
      tick(1);
    end
  endtask

  task automatic test_active_rot();
    int n = 0;
    s4r = 4'b1010;
    pulse_reset();
    while (st4r !== 2'b01 && n < 30) begin tick(1); n++; end
    checks++;
    if (st4r !== 2'b01 || l4r !== 4'b0000 || p4r !== 2'd0) begin
      errors++; $display("FAIL act_entry: got st=%b lamp=%b ptr=%0d want 01/0000/0", st4r, l4r, p4r);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (l4r !== (i % 2 == 0 ? 4'b0010 : 4'b1000)) begin
        errors++; $display("FAIL act_rot step%0d: got %b want %b", i, l4r, (i % 2 == 0 ? 4'b0010 : 4'b1000));
      end
    end
    s4r = 4'b0010;
    tick(LAT + 3);
    checks++;
    if (l4r !== 4'b0010 || p4r !== 2'd1) begin errors++; $display("FAIL act_single: got lamp=%b ptr=%0d want 0010/1", l4r, p4r); end
    tick(3);
    checks++;
    if (l4r !== 4'b0010) begin errors++; $display("FAIL act_single_hold: got %b want 0010", l4r); end
    s4r = 4'b0000;
    tick(LAT);
    checks++;
    if (st4r !== 2'b00 || l4r !== 4'b0000 || p4r !== 2'd1) begin
      errors++; $display("FAIL act_none_retain: got st=%b lamp=%b ptr=%0d want 00/0000/1", st4r, l4r, p4r);
    end
  endtask

  task automatic test_enable();
    s4 = 4'b0101;
    pulse_reset();
    wait_some4("enable");
    tick(4);
    checks++;
    if (l4 !== 4'b0010 || p4 !== 2'd1) begin errors++; $display("FAIL en_pre: got lamp=%b ptr=%0d want 0010/1", l4, p4); end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (l4 !== 4'b0000 || p4 !== 2'd1 || st4 !== 2'b01) begin
        errors++; $display("FAIL en_frozen cyc%0d: got lamp=%b ptr=%0d st=%b want 0000/1/01", i, l4, p4, st4);
      end
    end
    enable = 1'b1;
    #1;
    checks++;
    if (l4 !== 4'b0010) begin errors++; $display("FAIL en_resume: got %b want 0010", l4); end
    tick(1);
    checks++;
    if (l4 !== 4'b0010) begin errors++; $display("FAIL en_dwell_kept: got %b want 0010", l4); end
    tick(1);
    checks++;
    if (l4 !== 4'b0100 || p4 !== 2'd2) begin errors++; $display("FAIL en_advance: got lamp=%b ptr=%0d want 0100/2", l4, p4); end
  endtask

  task automatic test_reset_mid();
    tick(1);
    reset = 1'b1;
    tick(1);
    checks++;
    if (st4 !== 2'b00 || p4 !== 2'd0 || l4 !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: got st=%b ptr=%0d lamp=%b want 00/0/0000", st4, p4, l4);
    end
    reset = 1'b0;
    wait_some4("mid_reset");
    checks++;
    if (l4 !== 4'b0001) begin errors++; $display("FAIL mid_reset_restart: got %b want 0001", l4); end
    tick(3);
    checks++;
    if (l4 !== 4'b0010) begin errors++; $display("FAIL mid_reset_dwell: got %b want 0010", l4); end
  endtask

`ifdef SENSOR_ROTATOR_DEBOUNCE_EN
  task automatic test_debounce();
    s2 = 2'b00;
    pulse_reset();
    tick(3);
    s2 = 2'b01;
    tick(3);
    s2 = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (st2 !== 2'b00) begin errors++; $display("FAIL deb_glitch cyc%0d: got %b want 00", i, st2); end
    end
    s2 = 2'b01;
    tick(5);
    checks++;
    if (st2 !== 2'b00) begin errors++; $display("FAIL deb_early: got %b want 00", st2); end
    tick(1);
    checks++;
    if (st2 !== 2'b01) begin errors++; $display("FAIL deb_accept: got %b want 01", st2); end
    s2 = 2'b00;
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b1; s2 = '0; s4 = '0; s4r = '0;
    test_reset();
    test_n2_toggle();
    test_dwell();
    test_active_rot();
    test_enable();
    test_reset_mid();
`ifdef SENSOR_ROTATOR_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
